// File: rtl/io_input_reader_pkg.sv
// io_input_reader_pkg
//   Shared constants and types for the IO input reader block: the rd_addr
//   register map, port widths, the read FSM state type and a helper that
//   zero-extends the button vector onto the read data bus.
package io_input_reader_pkg;

   localparam int BTN_W = 5;
   localparam int DIP_W = 24;

   localparam logic [1:0] ADDR_DIP     = 2'd0;
   localparam logic [1:0] ADDR_BTN     = 2'd1;
   localparam logic [1:0] ADDR_PRESS   = 2'd2;
   localparam logic [1:0] ADDR_RELEASE = 2'd3;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   function automatic logic [DIP_W-1:0] zext_btn(input logic [BTN_W-1:0] v);
      return {{(DIP_W-BTN_W){1'b0}}, v};
   endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce
//   Two-flop synchronizer followed by a debouncer sharing one counter across
//   the whole WIDTH-bit vector. The debounced vector takes a new value only
//   after the synchronized vector has held that same value, different from
//   the current debounced value, for DEBOUNCE_CYCLES consecutive cycles.
//   Raw-to-debounced latency is 2+DEBOUNCE_CYCLES cycles.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     raw  : raw asynchronous input levels
//     deb  : debounced levels
module io_debounce #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] deb
);

   localparam int              CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;
   logic [WIDTH-1:0] sync_p2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         sync_p2 <= '0;
         cnt     <= '0;
         deb     <= '0;
      end else begin
         // synchronizer stages; sync_p2 remembers the previous synced value
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         // debounce stage
         if (sync_p1 == deb) begin
            cnt <= '0;
         end else if (sync_p1 != sync_p2) begin
            // a fresh change counts as the first cycle of its run, which
            // keeps the latency identical for single- and multi-bit use
            cnt <= CNT_W'(1);
         end else if (cnt == CNT_LAST) begin
            deb <= sync_p1;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_input_reader.sv
// io_input_reader
//   Debounces five push buttons and a 24-bit DIP switch bank, produces
//   one-cycle press pulses, keeps sticky press/release flags (cleared on
//   read) and serves a small register read port through an IDLE/RESP FSM.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : asynchronous active-high reset
//     io_btn    : raw button levels, 1 = pressed
//     io_dip    : raw DIP-switch levels
//     rd_req    : read request, sampled in IDLE only
//     rd_addr   : register select (DIP, buttons, sticky press, sticky release)
//     rd_valid  : one-cycle strobe qualifying rd_data
//     rd_data   : registered, zero-extended read data
//     btn_state : debounced button levels
//     btn_press : one-cycle pulse on each debounced 0->1 transition
//     irq       : OR of the sticky press flags
module io_input_reader
   import io_input_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_W-1:0] io_btn,
   input  logic [DIP_W-1:0] io_dip,
   input  logic             rd_req,
   input  logic [1:0]       rd_addr,
   output logic             rd_valid,
   output logic [DIP_W-1:0] rd_data,
   output logic [BTN_W-1:0] btn_state,
   output logic [BTN_W-1:0] btn_press,
   output logic             irq
);

   logic [BTN_W-1:0] btn_deb;
   logic [BTN_W-1:0] btn_deb_p1;
   logic [BTN_W-1:0] btn_release;
   logic [DIP_W-1:0] dip_deb;
   logic [BTN_W-1:0] sticky_press;
   logic [BTN_W-1:0] sticky_release;
   logic [BTN_W-1:0] clr_press;
   logic [BTN_W-1:0] clr_release;
   logic [DIP_W-1:0] rd_mux;
   logic             capture;
   rd_state_t        state;
   rd_state_t        state_nxt;

   for (genvar i = 0; i < BTN_W; i++) begin : g_btn
      io_debounce #(
         .WIDTH           (1),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_deb (
         .clk (clk),
         .rst (rst),
         .raw (io_btn[i]),
         .deb (btn_deb[i])
      );
   end

   io_debounce #(
      .WIDTH           (DIP_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dip_deb (
      .clk (clk),
      .rst (rst),
      .raw (io_dip),
      .deb (dip_deb)
   );

   // Edge detection against the previous debounced value: the press pulse
   // coincides with the first cycle btn_state reads 1.
   assign btn_state   = btn_deb;
   assign btn_press   = btn_deb & ~btn_deb_p1;
   assign btn_release = ~btn_deb & btn_deb_p1;
   assign irq         = |sticky_press;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      rd_valid  = 1'b0;
      case (state)
         RD_IDLE: begin
            if (rd_req) begin
               capture   = 1'b1;
               state_nxt = RD_RESP;
            end
         end
         RD_RESP: begin
            rd_valid  = 1'b1;
            state_nxt = RD_IDLE;
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_mux      = '0;
      clr_press   = '0;
      clr_release = '0;
      case (rd_addr)
         ADDR_DIP:     rd_mux = dip_deb;
         ADDR_BTN:     rd_mux = zext_btn(btn_deb);
         ADDR_PRESS:   rd_mux = zext_btn(sticky_press);
         ADDR_RELEASE: rd_mux = zext_btn(sticky_release);
         default:      rd_mux = '0;
      endcase
      // only the bits actually returned are cleared; an event landing on the
      // capture edge is ORed in afterwards and survives to the next read
      if (capture && rd_addr == ADDR_PRESS)   clr_press   = sticky_press;
      if (capture && rd_addr == ADDR_RELEASE) clr_release = sticky_release;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RD_IDLE;
         btn_deb_p1     <= '0;
         sticky_press   <= '0;
         sticky_release <= '0;
         rd_data        <= '0;
      end else begin
         state          <= state_nxt;
         btn_deb_p1     <= btn_deb;
         sticky_press   <= (sticky_press & ~clr_press) | btn_press;
         sticky_release <= (sticky_release & ~clr_release) | btn_release;
         if (capture) rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_io_input_reader.sv
module tb_io_input_reader;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  io_btn = '0;
   logic [23:0] io_dip = '0;
   logic        rd_req = 1'b0;
   logic [1:0]  rd_addr = '0;
   logic        rd_valid;
   logic [23:0] rd_data;
   logic [4:0]  btn_state;
   logic [4:0]  btn_press;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;

   io_input_reader #(.DEBOUNCE_CYCLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .io_btn    (io_btn),
      .io_dip    (io_dip),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .btn_state (btn_state),
      .btn_press (btn_press),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      io_btn = '0;
      io_dip = '0;
      rd_req = 1'b0;
      rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, output logic [23:0] d, output logic v);
      rd_req = 1'b1;
      rd_addr = a;
      tick();
      v = rd_valid;
      d = rd_data;
      rd_req = 1'b0;
      tick();
   endtask

   // ---------------- behavioural reference model ----------------
   // Synced sample seen at an edge is the raw value from two edges earlier.
   // A debounced value changes once the synced value has shown the same new
   // value for N consecutive edges.
   logic [28:0] raw_q[$];
   bit   [4:0]  m_deb, m_deb_prev, m_press, m_rel;
   bit   [23:0] m_dip, m_rd;
   bit          m_resp;
   int          run_len[5];
   bit          run_val[5];
   int          dip_len;
   bit   [23:0] dip_val;

   task automatic model_reset();
      raw_q.delete();
      m_deb = '0; m_deb_prev = '0; m_press = '0; m_rel = '0;
      m_dip = '0; m_rd = '0; m_resp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run_len[i] = N;
         run_val[i] = 1'b0;
      end
      dip_len = N;
      dip_val = '0;
   endtask

   task automatic model_step();
      logic [28:0] s;
      bit   [4:0]  pcur, rcur, clrp, clrr;
      raw_q.push_back({io_dip, io_btn});
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      s = (raw_q.size() == 3) ? raw_q[0] : '0;
      pcur = m_deb & ~m_deb_prev;
      rcur = ~m_deb & m_deb_prev;
      clrp = '0;
      clrr = '0;
      if (!m_resp && rd_req) begin
         case (rd_addr)
            2'd0: m_rd = m_dip;
            2'd1: m_rd = {19'd0, m_deb};
            2'd2: begin m_rd = {19'd0, m_press}; clrp = m_press; end
            default: begin m_rd = {19'd0, m_rel}; clrr = m_rel; end
         endcase
         m_resp = 1'b1;
      end else begin
         m_resp = 1'b0;
      end
      m_press = (m_press & ~clrp) | pcur;
      m_rel   = (m_rel & ~clrr) | rcur;
      m_deb_prev = m_deb;
      for (int i = 0; i < 5; i++) begin
         if (s[i] == run_val[i]) begin
            if (run_len[i] < 1000) run_len[i]++;
         end else begin
            run_val[i] = s[i];
            run_len[i] = 1;
         end
         if (run_len[i] >= N && run_val[i] != m_deb[i]) m_deb[i] = run_val[i];
      end
      if (s[28:5] == dip_val) begin
         if (dip_len < 1000) dip_len++;
      end else begin
         dip_val = s[28:5];
         dip_len = 1;
      end
      if (dip_len >= N && dip_val != m_dip) m_dip = dip_val;
   endtask

   typedef struct {
      logic [23:0] dip;
      logic [4:0]  btn;
      logic [1:0]  addr;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [23:0] d;
      logic        v;
      logic        b;

      tbl[0] = '{24'hA5C3F0, 5'h00, 2'd0, 24'hA5C3F0};
      tbl[1] = '{24'h000000, 5'h00, 2'd0, 24'h000000};
      tbl[2] = '{24'hFFFFFF, 5'h00, 2'd0, 24'hFFFFFF};
      tbl[3] = '{24'h123456, 5'h1F, 2'd1, 24'h00001F};
      tbl[4] = '{24'h123456, 5'h0A, 2'd1, 24'h00000A};
      tbl[5] = '{24'h800001, 5'h0A, 2'd0, 24'h800001};
      tbl[6] = '{24'h800001, 5'h00, 2'd1, 24'h000000};

      // reset state with inputs active
      rst = 1'b1;
      io_btn = 5'h1F;
      io_dip = 24'hFFFFFF;
      repeat (8) @(posedge clk);
      #1;
      check("reset_rd_valid", 32'(rd_valid), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_btn_state", 32'(btn_state), 32'd0);
      check("reset_btn_press", 32'(btn_press), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);

      // table-driven register reads
      do_reset();
      for (int i = 0; i < 7; i++) begin
         io_dip = tbl[i].dip;
         io_btn = tbl[i].btn;
         repeat (N + 4) tick();
         do_read(tbl[i].addr, d, v);
         check($sformatf("tbl%0d_valid", i), 32'(v), 32'd1);
         check($sformatf("tbl%0d_data", i), 32'(d), 32'(tbl[i].exp));
         check($sformatf("tbl%0d_valid_drop", i), 32'(rd_valid), 32'd0);
      end

      // single press on btn[0]: state 6 edges after the raw change
      do_reset();
      io_btn = 5'b00001;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("press0_state_k%0d", k), 32'(btn_state[0]), 32'(k >= 6));
         check($sformatf("press0_pulse_k%0d", k), 32'(btn_press[0]), 32'(k == 6));
         check($sformatf("press0_irq_k%0d", k), 32'(irq), 32'(k >= 7));
      end

      // bouncing btn[2]
      do_reset();
      for (int c = 0; c <= 22; c++) begin
         b = (c < 3) ? 1'b1 : (c < 6) ? 1'b0 : (c < 9) ? 1'b1 : (c < 12) ? 1'b0 : 1'b1;
         io_btn[2] = b;
         tick();
         check($sformatf("bounce_state_c%0d", c), 32'(btn_state[2]), 32'(c >= 17));
         check($sformatf("bounce_pulse_c%0d", c), 32'(btn_press[2]), 32'(c == 17));
      end

      // sticky press clear-on-read, release read, rd_data hold
      do_reset();
      io_btn = 5'b00010;
      repeat (N + 4) tick();
      check("sticky_irq_set", 32'(irq), 32'd1);
      do_read(2'd2, d, v);
      check("sticky_rd1_valid", 32'(v), 32'd1);
      check("sticky_rd1_data", 32'(d), 32'h000002);
      check("sticky_irq_cleared", 32'(irq), 32'd0);
      do_read(2'd2, d, v);
      check("sticky_rd2_data", 32'(d), 32'h000000);
      io_btn = 5'b00000;
      repeat (N + 4) tick();
      do_read(2'd3, d, v);
      check("release_rd_data", 32'(d), 32'h000002);
      repeat (5) tick();
      check("rd_data_hold", 32'(rd_data), 32'h000002);
      check("rd_valid_idle", 32'(rd_valid), 32'd0);
      do_read(2'd3, d, v);
      check("release_rd2_data", 32'(d), 32'h000000);

      // btn[3] press lands on the capture edge
      do_reset();
      io_btn = 5'b00010;
      repeat (N + 4) tick();
      io_btn = 5'b01010;
      repeat (6) tick();
      check("collide_pulse3", 32'(btn_press[3]), 32'd1);
      do_read(2'd2, d, v);
      check("collide_rd1_data", 32'(d), 32'h000002);
      check("collide_irq_kept", 32'(irq), 32'd1);
      do_read(2'd2, d, v);
      check("collide_rd2_data", 32'(d), 32'h000008);

      // reset asserted while in RESP, button held across reset
      do_reset();
      io_btn = 5'b10000;
      io_dip = 24'h00FF00;
      repeat (N + 4) tick();
      rd_req = 1'b1;
      rd_addr = 2'd0;
      @(posedge clk);
      rst = 1'b1;
      rd_req = 1'b0;
      #1;
      check("rstresp_rd_valid", 32'(rd_valid), 32'd0);
      check("rstresp_rd_data", 32'(rd_data), 32'd0);
      check("rstresp_btn_state", 32'(btn_state), 32'd0);
      check("rstresp_btn_press", 32'(btn_press), 32'd0);
      check("rstresp_irq", 32'(irq), 32'd0);
      repeat (2) tick();
      check("rstresp_held_valid", 32'(rd_valid), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check($sformatf("rstrel_pulse4_k%0d", k), 32'(btn_press[4]), 32'(k == 6));
         check($sformatf("rstrel_valid_k%0d", k), 32'(rd_valid), 32'd0);
      end

      // randomized traffic against the reference model
      rst = 1'b1;
      io_btn = '0;
      io_dip = '0;
      rd_req = 1'b0;
      rd_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(11) == 0) io_btn[$urandom_range(4)] = ~io_btn[$urandom_range(4)];
         if ($urandom_range(39) == 0) io_dip = 24'($urandom);
         if ($urandom_range(79) == 0) io_dip[$urandom_range(23)] = ~io_dip[0];
         rd_req = ($urandom_range(2) == 0);
         rd_addr = 2'($urandom_range(3));
         model_step();
         tick();
         check("rnd_btn_state", 32'(btn_state), 32'(m_deb));
         check("rnd_btn_press", 32'(btn_press), 32'(m_deb & ~m_deb_prev));
         check("rnd_irq", 32'(irq), 32'(|m_press));
         check("rnd_rd_valid", 32'(rd_valid), 32'(m_resp));
         check("rnd_rd_data", 32'(rd_data), 32'(m_rd));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
